// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Fetch/decode/execute controller for the 8-bit processor with
//               data-memory handshake, branch/jump resolution and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] saidaInstrucao,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic [7:0] pccounter,
    output logic [7:0] ir,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [1:0] reg_sel,
    output logic [4:0] imm,
    output logic       imm_load,
    output logic       reg_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_load,
    output logic       halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_MFI  = 3'b001;
    localparam logic [2:0] OP_MW   = 3'b010;
    localparam logic [2:0] OP_MR   = 3'b011;
    localparam logic [2:0] OP_BRZ  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_MB   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] w_done_state;
    logic [2:0] w_opcode;
    logic [7:0] w_branch_target;
    logic       w_exec;
    logic       w_mem;

    assign w_opcode     = ir[7:5];
    assign w_exec       = (r_state == S_EXEC);
    assign w_mem        = (r_state == S_MEM);
    // run is only consulted when an instruction retires
    assign w_done_state = run ? S_FETCH : S_IDLE;
    // pccounter already points past the branch during EXEC
    assign w_branch_target = pccounter + {{3{ir[4]}}, ir[4:0]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                case (w_opcode)
                    OP_MW, OP_MR: w_next_state = S_MEM;
                    OP_HALT:      w_next_state = S_HALT;
                    default:      w_next_state = w_done_state;
                endcase
            end
            S_MEM:    if (mem_ready) w_next_state = w_done_state;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            pccounter <= 8'd0;
            ir        <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                ir        <= saidaInstrucao;
                pccounter <= pccounter + 8'd1;
            end else if (w_exec) begin
                if (w_opcode == OP_BRZ && zero_flag)
                    pccounter <= w_branch_target;
                else if (w_opcode == OP_JMP)
                    pccounter <= {pccounter[7:5], ir[4:0]};
            end
        end
    end

    assign alu_op    = ir[2:0];
    assign reg_sel   = ir[4:3];
    assign imm       = ir[4:0];

    assign alu_en    = w_exec && (w_opcode == OP_ALU);
    assign imm_load  = w_exec && (w_opcode == OP_MFI);
    assign reg_write = w_exec && (w_opcode == OP_MB);
    assign mem_req   = w_mem;
    assign mem_we    = w_mem && (w_opcode == OP_MW);
    assign mem_load  = w_mem && mem_ready && (w_opcode == OP_MR);
    assign halted    = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit processor. It drives `pccounter` into `memoryinstruction` and accounts for that memory's one-cycle registered read latency. It latches each instruction, decodes it, and issues one-cycle execute strobes to the ALU, register file and data memory. It also sequences the data-memory handshake for MW/MR, resolves branches and jumps, and stops on HALT.

## Interface
- No parameters. Widths are fixed at 8-bit address and 8-bit instruction.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue enable.
- `saidaInstrucao` in 8: instruction word from `memoryinstruction`, valid one edge after `pccounter` is presented.
- `zero_flag` in 1: ALU zero flag, used by BRZ.
- `mem_ready` in 1: data-memory completion for MW/MR.
- `pccounter` out 8: instruction address.
- `ir` out 8: latched instruction register.
- `alu_en` out 1: ALU-operation strobe.
- `alu_op` out 3: `ir[2:0]`.
- `reg_sel` out 2: `ir[4:3]`.
- `imm` out 5: `ir[4:0]`.
- `imm_load` out 1: MFI strobe.
- `reg_write` out 1: MB strobe.
- `mem_req` out 1: data-memory request.
- `mem_we` out 1: 1 for MW, 0 for MR; meaningful only while `mem_req`=1.
- `mem_load` out 1: MR data-capture strobe.
- `halted` out 1: sequencer is stopped on HALT.

## Operation
- Opcode is `ir[7:5]`:
  - 000 ALU: register `[4:3]`, funct `[2:0]`.
  - 001 MFI: `imm[4:0]`.
  - 010 MW.
  - 011 MR.
  - 100 BRZ: signed 5-bit offset.
  - 101 JMP.
  - 110 MB.
  - 111 HALT.
- States are IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: go to FETCH when `run`=1.
- FETCH: present `pccounter` for one cycle, then go to DECODE.
- DECODE: `ir` <= `saidaInstrucao`; `pccounter` <= `pccounter`+1 (mod 256); go to EXEC.
- EXEC: lasts one cycle. Strobes are decoded combinationally from state==EXEC and `ir`:
  - 000: `alu_en`=1.
  - 001: `imm_load`=1.
  - 110: `reg_write`=1.
  - 100: if `zero_flag`=1, `pccounter` <= `pccounter` + sign_extend(`ir[4:0]`), mod 256. The offset is relative to the already-incremented PC.
  - 101: `pccounter` <= {`pccounter[7:5]`, `ir[4:0]`}, a jump within the current 32-byte page.
  - 010/011: go to MEM.
  - 111: go to HALT.
  - All other opcodes: go to FETCH if `run`=1, else IDLE.
- MEM:
  - `mem_req`=1; `mem_we`=(opcode==010).
  - Stay in MEM until `mem_ready`=1 is sampled on an edge.
  - In that cycle `mem_load`=1 if the opcode is MR.
  - Then go to FETCH/IDLE by `run`, as for EXEC.
- HALT: `halted`=1; stays in HALT until `reset`. `run` is ignored.
- `run` is sampled only at instruction completion. Deasserting it never aborts an instruction in progress.
- Only one strobe among `alu_en`, `imm_load`, `reg_write` and `mem_load` is ever high in a given cycle.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE; `pccounter`=0; `ir`=0.
  - All strobes, `mem_req`, `mem_we` and `halted` are 0.
  - This applies immediately from any state, including mid-MEM.
- Non-memory instruction: 3 cycles (FETCH, DECODE, EXEC). Memory instruction: 3 + N cycles, where N ≥ 1 is the number of MEM cycles.
- EXEC strobes are high for exactly one cycle.
- `mem_ready` already high on the first MEM cycle completes the access in one cycle.
- `mem_ready` outside MEM is ignored.
- `pccounter` is stable throughout FETCH. It changes only on the DECODE edge and the EXEC (branch/jump) edge.
- PC wrap: 255 -> 0 on increment. Branch arithmetic is mod 256.
- Decoded fields (`alu_op`, `reg_sel`, `imm`) track `ir` continuously. They are qualified only by the strobes.

## Test plan
- **Reset values:** assert `reset`=0 mid-run with `run`=1 -> `pccounter`=0, `ir`=0, all strobes 0, state IDLE; after release, the first FETCH shows `pccounter`=0.
- **Straight-line execution:** memory[0]=00000000, [1]=00100111 (MFI 7), [2]=00000010 -> `alu_en` pulses for address 0; `imm_load`=1 with `imm`=7 for exactly one cycle, 3 cycles later; `alu_en`, `alu_op`=010 for address 2; `pccounter` sequence 0,1,2,3.
- **BRZ:** at address 5, BRZ −3 (10011101) -> with `zero_flag`=1, next fetch is address 3; with `zero_flag`=0, next fetch is address 6.
- **MW handshake:** MW at address 12 with `mem_ready` delayed 3 cycles -> `mem_req`=1 and `mem_we`=1 for exactly 3 cycles; next FETCH at address 13. MR with immediate `mem_ready` -> one MEM cycle with `mem_load`=1.
- **Reset during MEM:** reset asserted during MEM -> `mem_req` drops asynchronously, `pccounter`=0.
- **HALT and wrap:**
  - HALT (11100000) -> `halted`=1 and `pccounter` frozen, even with `run` toggling.
  - Separately, an instruction at address 255 -> next fetch is address 0.
  - `run`=0 during EXEC -> IDLE after completion; no further FETCH until `run`=1.
